cart_bus_master: RTL and testbench
==================================

# cart_bus_master

Bus initiator for the GameBoy cartridge interface: it drives address, A15/chip-select, #rd, #wr and data the way the DMG CPU does, so the FPGA can read and write a real cartridge (ROM dumping, MBC bank register writes). It is the opposite end of the FPGA's ROM-emulation responder. It sits between a simple request/response port (fed by a host-side controller) and the SB_IO-registered cartridge pins.

## Interface
- SETUP_TICKS, default 4: clk cycles with address/cs (and write data) valid before the strobe asserts; minimum 1.
- STROBE_TICKS, default 8: clk cycles that #rd or #wr is held low; minimum 1.
- HOLD_TICKS, default 2: clk cycles that address/data are held after the strobe deasserts; minimum 1.
- CNT_WIDTH, default 4: tick counter width; must hold max(SETUP_TICKS, STROBE_TICKS, HOLD_TICKS)-1.

Ports:
- clk  in  1  PLL clock. One clock domain; reset is synchronous and active-low.
- n_reset  in  1  Synchronous reset, active low.
- req_valid  in  1  Request present.
- req_ready  out  1  Block idle; a request is accepted on an edge where req_valid && req_ready.
- req_write  in  1  1 = write cycle, 0 = read cycle.
- req_adr  in  16  Full address; bit 15 drives n_cs_out.
- req_data  in  8  Write data.
- rsp_valid  out  1  One-cycle pulse when a cycle completes, for both reads and writes.
- rsp_data  out  8  Captured read data; unchanged by write cycles.
- adr_out  out  15  A0–A14 to the pins.
- n_cs_out  out  1  A15 / ROM chip select.
- n_read_out  out  1  #rd.
- n_write_out  out  1  #wr.
- data_out  out  8  Data bus output value.
- data_drv  out  1  Data pad output enable; also drives the level-shifter direction.
- data_in  in  8  Data pins, already registered by SB_IO (one cycle old).

## Operation
- States:
  - IDLE: req_ready = 1.
  - SETUP, STROBE, HOLD: req_ready = 0.
- All outputs are registered.
- IDLE, on accept:
  - Latch adr_out = req_adr[14:0], n_cs_out = req_adr[15], data_out = req_data, data_drv = req_write.
  - Go to SETUP with cnt = SETUP_TICKS-1.
- SETUP:
  - cnt decrements each cycle.
  - At cnt == 0, go to STROBE with cnt = STROBE_TICKS-1.
  - On that transition, n_read_out = 0 for a read, or n_write_out = 0 for a write.
- STROBE:
  - cnt decrements each cycle.
  - At cnt == 0: both strobes go to 1. For a read, rsp_data <= data_in. Go to HOLD with cnt = HOLD_TICKS-1.
- HOLD:
  - cnt decrements each cycle.
  - At cnt == 0: rsp_valid <= 1 for one cycle, data_drv <= 0, n_cs_out <= 1, req_ready <= 1, go to IDLE.
  - adr_out and data_out keep their last values.
- A request arriving while busy is not accepted (req_ready = 0). req_* may change freely once accepted.
- #rd and #wr are never low simultaneously.
- data_drv is never 1 during a read cycle.

## Timing
- Reset values:
  - n_read_out = 1, n_write_out = 1, n_cs_out = 1.
  - adr_out = 0, data_out = 0, data_drv = 0.
  - rsp_valid = 0, rsp_data = 0.
  - req_ready = 1, state IDLE.
- Accept edge E0. The strobe asserts at E0+S and deasserts at E0+S+T. rsp_valid is high during the cycle after edge E0+S+T+H.
  - S = SETUP_TICKS, T = STROBE_TICKS, H = HOLD_TICKS.
- Read data: data_in sampled at E0+S+T reflects the pins one cycle earlier, while the strobe is still low.
- Back-to-back: the next accept can happen at E0+S+T+H+1. Minimum period is S+T+H+1 cycles (15 with defaults).
- req_ready and rsp_valid rise on the same edge.
- Reset mid-cycle: when n_reset is low at an edge, all outputs return to their reset values at that edge.
  - No rsp_valid is produced for the aborted cycle.
  - A strobe that was low goes high immediately.

## Test plan
- Reset values: hold n_reset low 3 cycles with req_valid = 1. All outputs must equal their reset values, and there must be no accept.
- Read, defaults: accept read 0x0104 with data_in = 0xCE.
  - adr_out = 0x104 and n_cs_out = 0 from E0.
  - n_read_out is low for exactly 8 cycles starting at E0+4.
  - rsp_valid pulses at E0+14 with rsp_data = 0xCE.
  - data_drv stays 0 throughout.
- Write: write 0x05 to 0x2000 (MBC1 bank select).
  - n_cs_out = 0, data_drv = 1 and data_out = 0x05 from E0 through HOLD.
  - n_write_out is low for 8 cycles.
  - rsp_valid pulses once; rsp_data is unchanged.
- Back-to-back: hold req_valid high and issue read 0x0000 then read 0x8000.
  - Second accept happens exactly 15 cycles after the first.
  - The second cycle has n_cs_out = 1 and adr_out = 0x000.
  - Two rsp_valid pulses.
- Reset mid-strobe: assert n_reset low during STROBE of a write.
  - n_write_out = 1 and data_drv = 0 on the next edge.
  - No rsp_valid.
  - A following read completes normally.
- Minimum parameters S = T = H = 1: read latency is 3 cycles to rsp_valid, the strobe is low for 1 cycle, and the period is 4 cycles.

Source files
------------

// File: rtl/cart_bus_master.sv
// cart_bus_master
// Bus initiator for the GameBoy cartridge slot. Drives address, A15/chip
// select, #rd, #wr and write data with DMG-style setup/strobe/hold timing so
// the FPGA can read and write a real cartridge.
//
// Ports:
//   clk, n_reset            clock and synchronous active-low reset
//   req_valid/req_ready     request handshake (accept on valid && ready)
//   req_write, req_adr,
//   req_data                request attributes (sampled at accept only)
//   rsp_valid, rsp_data     one-cycle completion pulse and captured read data
//   adr_out, n_cs_out       A0-A14 and A15/chip select to the pins
//   n_read_out, n_write_out #rd / #wr strobes
//   data_out, data_drv      data bus output value and pad/level-shifter enable
//   data_in                 data pins, registered once by the pad cell
module cart_bus_master #(
  parameter int SETUP_TICKS  = 4,
  parameter int STROBE_TICKS = 8,
  parameter int HOLD_TICKS   = 2,
  parameter int CNT_WIDTH    = 4
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_adr,
  input  logic [7:0]  req_data,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic [14:0] adr_out,
  output logic        n_cs_out,
  output logic        n_read_out,
  output logic        n_write_out,
  output logic [7:0]  data_out,
  output logic        data_drv,
  input  logic [7:0]  data_in
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  // Counters are loaded with N-1 and the phase ends on the cycle they hit zero.
  localparam logic [CNT_WIDTH-1:0] SETUP_LOAD  = CNT_WIDTH'(SETUP_TICKS - 1);
  localparam logic [CNT_WIDTH-1:0] STROBE_LOAD = CNT_WIDTH'(STROBE_TICKS - 1);
  localparam logic [CNT_WIDTH-1:0] HOLD_LOAD   = CNT_WIDTH'(HOLD_TICKS - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO    = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

  state_t                 state_r;
  logic [CNT_WIDTH-1:0]   cnt_r;
  logic                   is_write_r;
  logic                   req_ready_r;
  logic                   rsp_valid_r;
  logic [7:0]             rsp_data_r;
  logic [14:0]            adr_r;
  logic                   n_cs_r;
  logic                   n_read_r;
  logic                   n_write_r;
  logic [7:0]             data_r;
  logic                   data_drv_r;

  assign req_ready   = req_ready_r;
  assign rsp_valid   = rsp_valid_r;
  assign rsp_data    = rsp_data_r;
  assign adr_out     = adr_r;
  assign n_cs_out    = n_cs_r;
  assign n_read_out  = n_read_r;
  assign n_write_out = n_write_r;
  assign data_out    = data_r;
  assign data_drv    = data_drv_r;

  // Bus-cycle sequencer: all pin and handshake outputs are registered here.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= CNT_ZERO;
      is_write_r  <= 1'b0;
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= 8'h00;
      adr_r       <= 15'h0000;
      n_cs_r      <= 1'b1;
      n_read_r    <= 1'b1;
      n_write_r   <= 1'b1;
      data_r      <= 8'h00;
      data_drv_r  <= 1'b0;
    end else begin
      // rsp_valid is a single-cycle pulse unless re-armed below
      rsp_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (req_valid && req_ready_r) begin
            adr_r       <= req_adr[14:0];
            n_cs_r      <= req_adr[15];
            data_r      <= req_data;
            // the pad only drives for writes, so reads never fight the cart
            data_drv_r  <= req_write;
            is_write_r  <= req_write;
            req_ready_r <= 1'b0;
            cnt_r       <= SETUP_LOAD;
            state_r     <= ST_SETUP;
          end else begin
            req_ready_r <= 1'b1;
          end
        end
        ST_SETUP: begin
          if (cnt_r == CNT_ZERO) begin
            // exactly one strobe goes low, selected by the latched direction
            n_read_r  <= is_write_r;
            n_write_r <= ~is_write_r;
            cnt_r     <= STROBE_LOAD;
            state_r   <= ST_STROBE;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        ST_STROBE: begin
          if (cnt_r == CNT_ZERO) begin
            n_read_r  <= 1'b1;
            n_write_r <= 1'b1;
            // data_in lags the pins by one cycle, so this is the value seen
            // while #rd was still low
            if (!is_write_r) begin
              rsp_data_r <= data_in;
            end else begin
              rsp_data_r <= rsp_data_r;
            end
            cnt_r   <= HOLD_LOAD;
            state_r <= ST_HOLD;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        ST_HOLD: begin
          if (cnt_r == CNT_ZERO) begin
            rsp_valid_r <= 1'b1;
            data_drv_r  <= 1'b0;
            n_cs_r      <= 1'b1;
            req_ready_r <= 1'b1;
            state_r     <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          cnt_r       <= CNT_ZERO;
          req_ready_r <= 1'b1;
          n_cs_r      <= 1'b1;
          n_read_r    <= 1'b1;
          n_write_r   <= 1'b1;
          data_drv_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cart_bus_master.sv
module tb_cart_bus_master;

  logic        clk;
  logic        n_reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [15:0] req_adr;
  logic [7:0]  req_data;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic [14:0] adr_out;
  logic        n_cs_out;
  logic        n_read_out;
  logic        n_write_out;
  logic [7:0]  data_out;
  logic        data_drv;
  logic [7:0]  data_in;

  // second instance with minimum timing parameters
  logic        m_req_valid;
  logic        m_req_ready;
  logic        m_req_write;
  logic [15:0] m_req_adr;
  logic [7:0]  m_req_data;
  logic        m_rsp_valid;
  logic [7:0]  m_rsp_data;
  logic [14:0] m_adr_out;
  logic        m_n_cs_out;
  logic        m_n_read_out;
  logic        m_n_write_out;
  logic [7:0]  m_data_out;
  logic        m_data_drv;
  logic [7:0]  m_data_in;

  int n_asserts = 0;
  int n_fail    = 0;
  int rsp_count = 0;
  logic [7:0] sb_q[$];
  logic [7:0] model_rsp;

  cart_bus_master dut (
    .clk(clk), .n_reset(n_reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_adr(req_adr), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .adr_out(adr_out), .n_cs_out(n_cs_out),
    .n_read_out(n_read_out), .n_write_out(n_write_out),
    .data_out(data_out), .data_drv(data_drv), .data_in(data_in)
  );

  cart_bus_master #(
    .SETUP_TICKS(1), .STROBE_TICKS(1), .HOLD_TICKS(1), .CNT_WIDTH(1)
  ) dut_min (
    .clk(clk), .n_reset(n_reset),
    .req_valid(m_req_valid), .req_ready(m_req_ready), .req_write(m_req_write),
    .req_adr(m_req_adr), .req_data(m_req_data),
    .rsp_valid(m_rsp_valid), .rsp_data(m_rsp_data),
    .adr_out(m_adr_out), .n_cs_out(m_n_cs_out),
    .n_read_out(m_n_read_out), .n_write_out(m_n_write_out),
    .data_out(m_data_out), .data_drv(m_data_drv), .data_in(m_data_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(input int budget);
    for (int k = 0; k < budget; k++) begin
      tick();
      if (rsp_valid) break;
    end
    check("rsp_timeout", {31'd0, rsp_valid}, 32'd1);
    tick();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_n_read"},  {31'd0, n_read_out},  32'd1);
    check({tag, "_n_write"}, {31'd0, n_write_out}, 32'd1);
    check({tag, "_n_cs"},    {31'd0, n_cs_out},    32'd1);
    check({tag, "_adr"},     {17'd0, adr_out},     32'd0);
    check({tag, "_data"},    {24'd0, data_out},    32'd0);
    check({tag, "_drv"},     {31'd0, data_drv},    32'd0);
    check({tag, "_rsp_v"},   {31'd0, rsp_valid},   32'd0);
    check({tag, "_rsp_d"},   {24'd0, rsp_data},    32'd0);
    check({tag, "_ready"},   {31'd0, req_ready},   32'd1);
  endtask

  // Scoreboard: every completion pops the response expected at accept time.
  always @(negedge clk) begin
    if (n_reset === 1'b1 && rsp_valid === 1'b1) begin
      rsp_count++;
      if (sb_q.size() == 0) begin
        check("rsp_unexpected", sb_q.size(), 32'd1);
      end else begin
        check("rsp_data", {24'd0, rsp_data}, {24'd0, sb_q.pop_front()});
      end
    end
  end

  initial begin
    int   second_k;
    int   cnt0;
    logic prev;

    n_reset = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_adr = 16'h1234; req_data = 8'hAA;
    data_in = 8'h00;
    m_req_valid = 1'b0; m_req_write = 1'b0; m_req_adr = 16'h0000;
    m_req_data = 8'h00; m_data_in = 8'h00;
    model_rsp = 8'h00;

    // reset held 3 cycles with a pending request
    for (int k = 0; k < 3; k++) begin
      tick();
      check_reset_vals("reset");
    end
    req_valid = 1'b0;
    n_reset = 1'b1;
    tick();
    check_reset_vals("post_reset");

    // read 0x0104, data 0xCE
    req_valid = 1'b1; req_write = 1'b0; req_adr = 16'h0104; data_in = 8'hCE;
    tick();
    sb_q.push_back(8'hCE); model_rsp = 8'hCE;
    req_valid = 1'b0; req_adr = 16'hFFFF;
    check("rd_ready", {31'd0, req_ready}, 32'd0);
    check("rd_adr", {17'd0, adr_out}, 32'h104);
    check("rd_cs", {31'd0, n_cs_out}, 32'd0);
    for (int k = 1; k <= 14; k++) begin
      tick();
      check("rd_n_read", {31'd0, n_read_out}, (k >= 4 && k < 12) ? 32'd0 : 32'd1);
      check("rd_n_write", {31'd0, n_write_out}, 32'd1);
      check("rd_drv", {31'd0, data_drv}, 32'd0);
      check("rd_rsp_valid", {31'd0, rsp_valid}, (k == 14) ? 32'd1 : 32'd0);
      if (k < 14) check("rd_cs_hold", {31'd0, n_cs_out}, 32'd0);
    end
    check("rd_ready_back", {31'd0, req_ready}, 32'd1);
    tick();
    check("rd_rsp_single", {31'd0, rsp_valid}, 32'd0);

    // write 0x05 to 0x2000
    req_valid = 1'b1; req_write = 1'b1; req_adr = 16'h2000; req_data = 8'h05;
    data_in = 8'h77;
    tick();
    sb_q.push_back(model_rsp);
    req_valid = 1'b0; req_data = 8'hFF;
    check("wr_adr", {17'd0, adr_out}, 32'h2000);
    for (int k = 0; k <= 15; k++) begin
      if (k > 0) tick();
      if (k < 14) begin
        check("wr_cs", {31'd0, n_cs_out}, 32'd0);
        check("wr_drv", {31'd0, data_drv}, 32'd1);
        check("wr_data", {24'd0, data_out}, 32'h05);
      end else begin
        check("wr_drv_off", {31'd0, data_drv}, 32'd0);
        check("wr_cs_off", {31'd0, n_cs_out}, 32'd1);
      end
      check("wr_n_write", {31'd0, n_write_out}, (k >= 4 && k < 12) ? 32'd0 : 32'd1);
      check("wr_n_read", {31'd0, n_read_out}, 32'd1);
      check("wr_rsp_valid", {31'd0, rsp_valid}, (k == 14) ? 32'd1 : 32'd0);
    end
    check("wr_rsp_data_kept", {24'd0, rsp_data}, 32'hCE);

    // back-to-back reads 0x0000 then 0x8000
    cnt0 = rsp_count;
    req_valid = 1'b1; req_write = 1'b0; req_adr = 16'h0000; data_in = 8'h31;
    tick();
    sb_q.push_back(8'h31); model_rsp = 8'h31;
    check("b2b_accept1", {31'd0, req_ready}, 32'd0);
    req_adr = 16'h8000;
    second_k = 0;
    for (int k = 1; k <= 30; k++) begin
      prev = req_ready;
      tick();
      if (prev && !req_ready) begin
        second_k = k;
        break;
      end
    end
    sb_q.push_back(8'h7A); model_rsp = 8'h7A;
    data_in = 8'h7A;
    req_valid = 1'b0;
    check("b2b_period", second_k, 32'd15);
    check("b2b_cs", {31'd0, n_cs_out}, 32'd1);
    check("b2b_adr", {17'd0, adr_out}, 32'h0);
    wait_rsp(20);
    check("b2b_rsp_count", rsp_count - cnt0, 32'd2);

    // reset asserted during the strobe of a write
    cnt0 = rsp_count;
    req_valid = 1'b1; req_write = 1'b1; req_adr = 16'h3000; req_data = 8'h0A;
    tick();
    req_valid = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    check("mid_strobe_low", {31'd0, n_write_out}, 32'd0);
    n_reset = 1'b0;
    tick();
    model_rsp = 8'h00;
    check_reset_vals("mid_reset");
    n_reset = 1'b1;
    for (int k = 0; k < 20; k++) tick();
    check("mid_no_rsp", rsp_count - cnt0, 32'd0);

    // following read completes normally
    req_valid = 1'b1; req_write = 1'b0; req_adr = 16'h4000; data_in = 8'h5C;
    tick();
    sb_q.push_back(8'h5C); model_rsp = 8'h5C;
    req_valid = 1'b0;
    wait_rsp(20);
    check("after_reset_rsp", rsp_count - cnt0, 32'd1);
    check("sb_empty", sb_q.size(), 32'd0);

    // minimum timing instance: S = T = H = 1
    m_req_valid = 1'b1; m_req_write = 1'b0; m_req_adr = 16'h0150; m_data_in = 8'h99;
    tick();
    check("min_accept", {31'd0, m_req_ready}, 32'd0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("min_n_read", {31'd0, m_n_read_out}, (k == 1) ? 32'd0 : 32'd1);
      check("min_rsp_valid", {31'd0, m_rsp_valid}, (k == 3) ? 32'd1 : 32'd0);
      if (k == 3) begin
        check("min_rsp_data", {24'd0, m_rsp_data}, 32'h99);
        check("min_ready", {31'd0, m_req_ready}, 32'd1);
      end
      if (k == 4) check("min_period", {31'd0, m_req_ready}, 32'd0);
    end
    m_req_valid = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    check("min_idle", {31'd0, m_req_ready}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
